// File: rtl/modbus_pkg.sv
// rtl/modbus_pkg.sv - shared Modbus RTU definitions
// Purpose: FSM state encoding, CRC16 constants and the t3.5 silent-interval
// calculation shared by the frame transmitter and the receive-side checker.
// Ports: none (package).
package modbus_pkg;

  // One-hot encoding: each state decodes from a single flop.
  typedef enum logic [7:0] {
    ST_IDLE      = 8'b0000_0001,
    ST_FETCH     = 8'b0000_0010,
    ST_SEND      = 8'b0000_0100,
    ST_WAIT_DONE = 8'b0000_1000,
    ST_CRC_LO    = 8'b0001_0000,
    ST_CRC_HI    = 8'b0010_0000,
    ST_GAP       = 8'b0100_0000,
    ST_DONE      = 8'b1000_0000
  } state_t;

  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'hA001;

  // Above 19200 baud Modbus fixes t3.5 at 1.75 ms; at or below it is
  // 3.5 character times of 11 bits each (77/2 bit times).
  function automatic longint unsigned calc_t35(input longint unsigned clk,
                                               input longint unsigned baud);
    if (baud > 64'd19200) begin
      return (clk * 64'd1750) / 64'd1000000;
    end
    return (clk * 64'd77) / (64'd2 * baud);
  endfunction

endpackage

// File: rtl/modbus_crc16_byte.sv
// rtl/modbus_crc16_byte.sv - combinational Modbus CRC16 single-byte fold
// Purpose: next CRC after folding one byte, LSB first, reflected poly 0xA001.
// Ports:
//   crc_in  [15:0] in   running CRC before this byte
//   data    [7:0]  in   byte to fold in
//   crc_out [15:0] out  running CRC after this byte
module modbus_crc16_byte
  import modbus_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  logic [15:0] crc_v;

  always_comb begin
    crc_v = crc_in ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      if (crc_v[0]) begin
        crc_v = (crc_v >> 1) ^ CRC_POLY;
      end else begin
        crc_v = crc_v >> 1;
      end
    end
    crc_out = crc_v;
  end

endmodule

// File: rtl/modbus_frame_tx.sv
// rtl/modbus_frame_tx.sv - Modbus RTU frame transmitter sequencer
// Purpose: sends a buffered frame of 1..MAX_LEN bytes through uart_byte_tx,
// optionally appends CRC16 (low byte first), then holds the t3.5 gap.
// Ports:
//   sys_clk, reset_n              clock, asynchronous active-low reset
//   wr_en, wr_addr, wr_data       frame buffer write port (ignored while busy)
//   frame_start, frame_len, crc_en  frame request, sampled together
//   busy, frame_done, frame_err   frame status
//   gap_active                    high while the t3.5 gap is counted
//   crc_out                       CRC of the last completed frame
//   tx_start, tx_data, tx_done    handshake with uart_byte_tx
module modbus_frame_tx
  import modbus_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200,
  parameter int MAX_LEN   = 256,
  parameter int ADDR_W    = 8,
  parameter int LEN_W     = 9
) (
  input  logic              sys_clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              frame_start,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic              crc_en,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err,
  output logic              gap_active,
  output logic [15:0]       crc_out,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_done
);

  localparam logic [31:0] T35_CYC = 32'(calc_t35(64'(CLK_FREQ), 64'(BAUD_RATE)));

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  idx, idx_nxt;
  logic [LEN_W-1:0]  len_q, len_nxt;
  logic              crc_en_q, crc_en_nxt;
  logic [15:0]       crc_q, crc_nxt, crc_fold;
  logic [31:0]       gap_cnt, gap_nxt;
  logic              tx_start_nxt;
  logic [7:0]        tx_data_nxt;
  logic              frame_err_nxt;
  logic [15:0]       crc_out_nxt;

  logic [7:0]        mem [MAX_LEN];
  logic [7:0]        rd_data;

  logic              len_ok;
  logic              wr_ok;
  logic              last_byte;

  assign len_ok    = (frame_len != '0) && (frame_len <= LEN_W'(MAX_LEN));
  assign wr_ok     = ({{(32-ADDR_W){1'b0}}, wr_addr} < 32'(MAX_LEN));
  assign last_byte = (idx == len_q - LEN_W'(1));

  assign busy       = (state != ST_IDLE);
  assign gap_active = (state == ST_GAP);
  assign frame_done = (state == ST_DONE);

  // Buffer: contents are not reset. The read port follows idx every cycle,
  // so the byte for idx is valid one cycle after FETCH presents it.
  always_ff @(posedge sys_clk) begin
    if (wr_en && !busy && wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[idx[ADDR_W-1:0]];
  end

  modbus_crc16_byte u_crc16 (
    .crc_in  (crc_q),
    .data    (rd_data),
    .crc_out (crc_fold)
  );

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    len_nxt       = len_q;
    crc_en_nxt    = crc_en_q;
    crc_nxt       = crc_q;
    gap_nxt       = gap_cnt;
    tx_start_nxt  = 1'b0;
    tx_data_nxt   = tx_data;
    frame_err_nxt = 1'b0;
    crc_out_nxt   = crc_out;

    case (state)
      ST_IDLE: begin
        if (frame_start) begin
          if (len_ok) begin
            len_nxt    = frame_len;
            crc_en_nxt = crc_en;
            idx_nxt    = '0;
            crc_nxt    = CRC_INIT;
            state_nxt  = ST_FETCH;
          end else begin
            frame_err_nxt = 1'b1;
          end
        end
      end
      ST_FETCH: begin
        state_nxt = ST_SEND;
      end
      ST_SEND: begin
        tx_data_nxt  = rd_data;
        tx_start_nxt = 1'b1;
        crc_nxt      = crc_fold;
        state_nxt    = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (tx_done) begin
          if (!last_byte) begin
            idx_nxt   = idx + LEN_W'(1);
            state_nxt = ST_FETCH;
          end else if (crc_en_q) begin
            tx_data_nxt  = crc_q[7:0];
            tx_start_nxt = 1'b1;
            state_nxt    = ST_CRC_LO;
          end else begin
            gap_nxt   = '0;
            state_nxt = ST_GAP;
          end
        end
      end
      ST_CRC_LO: begin
        if (tx_done) begin
          tx_data_nxt  = crc_q[15:8];
          tx_start_nxt = 1'b1;
          state_nxt    = ST_CRC_HI;
        end
      end
      ST_CRC_HI: begin
        if (tx_done) begin
          gap_nxt   = '0;
          state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt == T35_CYC - 32'd1) begin
          crc_out_nxt = crc_q;
          state_nxt   = ST_DONE;
        end else begin
          gap_nxt = gap_cnt + 32'd1;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      len_q     <= '0;
      crc_en_q  <= 1'b0;
      crc_q     <= CRC_INIT;
      gap_cnt   <= '0;
      tx_start  <= 1'b0;
      tx_data   <= 8'h00;
      frame_err <= 1'b0;
      crc_out   <= CRC_INIT;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      len_q     <= len_nxt;
      crc_en_q  <= crc_en_nxt;
      crc_q     <= crc_nxt;
      gap_cnt   <= gap_nxt;
      tx_start  <= tx_start_nxt;
      tx_data   <= tx_data_nxt;
      frame_err <= frame_err_nxt;
      crc_out   <= crc_out_nxt;
    end
  end

endmodule

// File: tb/tb_modbus_frame_tx.sv
// tb/tb_modbus_frame_tx.sv - directed self-checking bench for modbus_frame_tx
module tb_modbus_frame_tx;
  import modbus_pkg::*;

  localparam int CLK_HZ   = 1000000;
  localparam int UART_DLY = 6;
  localparam int T35_FAST = 1750;
  localparam int T35_SLOW = 4010;

  logic sys_clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic       wr_en = 1'b0;
  logic [7:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       frame_start = 1'b0;
  logic [8:0] frame_len = '0;
  logic       crc_en = 1'b0;
  logic       busy, frame_done, frame_err, gap_active, tx_start;
  logic [15:0] crc_out;
  logic [7:0] tx_data;
  logic       tx_done = 1'b0;

  logic       wr_en_s = 1'b0;
  logic [7:0] wr_addr_s = '0;
  logic [7:0] wr_data_s = '0;
  logic       frame_start_s = 1'b0;
  logic [8:0] frame_len_s = '0;
  logic       crc_en_s = 1'b0;
  logic       busy_s, frame_done_s, frame_err_s, gap_active_s, tx_start_s;
  logic [15:0] crc_out_s;
  logic [7:0] tx_data_s;
  logic       tx_done_s = 1'b0;

  modbus_frame_tx #(.CLK_FREQ(CLK_HZ), .BAUD_RATE(115200), .MAX_LEN(256),
                    .ADDR_W(8), .LEN_W(9)) dut (
    .sys_clk(sys_clk), .reset_n(reset_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_start(frame_start), .frame_len(frame_len), .crc_en(crc_en),
    .busy(busy), .frame_done(frame_done), .frame_err(frame_err),
    .gap_active(gap_active), .crc_out(crc_out),
    .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done)
  );

  modbus_frame_tx #(.CLK_FREQ(CLK_HZ), .BAUD_RATE(9600), .MAX_LEN(256),
                    .ADDR_W(8), .LEN_W(9)) dut_slow (
    .sys_clk(sys_clk), .reset_n(reset_n),
    .wr_en(wr_en_s), .wr_addr(wr_addr_s), .wr_data(wr_data_s),
    .frame_start(frame_start_s), .frame_len(frame_len_s), .crc_en(crc_en_s),
    .busy(busy_s), .frame_done(frame_done_s), .frame_err(frame_err_s),
    .gap_active(gap_active_s), .crc_out(crc_out_s),
    .tx_start(tx_start_s), .tx_data(tx_data_s), .tx_done(tx_done_s)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // UART stand-in and line monitor for the main instance.
  int         neg_idx = 0;
  int         last_done_neg = -1;
  int         uart_cnt = 0;
  logic [7:0] cur_byte = '0;
  logic [7:0] line_q[$];
  int         gaps_q[$];
  int         gap_cycles = 0, gap_first = -1, fd_neg = -1;
  int         done_cnt = 0, err_cnt = 0, busy_cycles = 0, stab_viol = 0;

  always @(negedge sys_clk) begin
    neg_idx++;
    tx_done = 1'b0;
    if (gap_active) begin
      if (gap_first < 0) gap_first = neg_idx;
      gap_cycles++;
    end
    if (frame_done) begin
      done_cnt++;
      fd_neg = neg_idx;
    end
    if (frame_err) err_cnt++;
    if (busy) busy_cycles++;
    if (tx_start) begin
      line_q.push_back(tx_data);
      gaps_q.push_back((last_done_neg >= 0) ? (neg_idx - last_done_neg) : -1);
      cur_byte = tx_data;
      uart_cnt = UART_DLY;
    end else if (uart_cnt > 0) begin
      if (tx_data !== cur_byte) stab_viol++;
      uart_cnt--;
      if (uart_cnt == 0) begin
        tx_done = 1'b1;
        last_done_neg = neg_idx;
      end
    end
  end

  task automatic clear_mon();
    line_q.delete();
    gaps_q.delete();
    gap_cycles = 0; gap_first = -1; fd_neg = -1; last_done_neg = -1;
    done_cnt = 0; err_cnt = 0; busy_cycles = 0; stab_viol = 0;
  endtask

  task automatic wr_byte(input logic [7:0] a, input logic [7:0] d);
    @(posedge sys_clk); #1;
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge sys_clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic send_frame(input logic [8:0] len, input logic ce);
    @(posedge sys_clk); #1;
    frame_len = len; crc_en = ce; frame_start = 1'b1;
    @(posedge sys_clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic wait_frame_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge sys_clk); #1;
      if (done_cnt > 0) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_bytes(input int n, input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge sys_clk); #1;
      if (line_q.size() >= n) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_line(input string tag, input logic [7:0] exp_b[$]);
    check_eq({tag, "_nbytes"}, 32'(line_q.size()), 32'(exp_b.size()));
    for (int i = 0; i < exp_b.size(); i++) begin
      check_eq($sformatf("%s_byte%0d", tag, i),
               (i < line_q.size()) ? {24'h0, line_q[i]} : 32'hDEAD, {24'h0, exp_b[i]});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    logic [7:0] exp_a[$] = '{8'hC2, 8'hB3, 8'hA4, 8'h95};
    logic [7:0] exp_b[$] = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
    logic [7:0] exp_c[$] = '{8'h01, 8'h03, 8'h00, 8'h00};
    logic [7:0] exp_d[$] = '{8'h01};
    int first_i, done_i, g;

    // Reset state
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check_eq("reset_flags", {27'h0, busy, frame_done, frame_err, gap_active, tx_start}, 32'h0);
    check_eq("reset_tx_data", {24'h0, tx_data}, 32'h00);
    check_eq("reset_crc_out", {16'h0, crc_out}, 32'hFFFF);
    check_eq("reset_slow_flags", {27'h0, busy_s, frame_done_s, frame_err_s, gap_active_s, tx_start_s}, 32'h0);
    @(posedge sys_clk); #1;
    reset_n = 1'b1;

    // t3.5 rule at the real clock rate, including the 19200 boundary
    check_eq("t35_115200", 32'(calc_t35(64'd50000000, 64'd115200)), 32'd87500);
    check_eq("t35_9600",   32'(calc_t35(64'd50000000, 64'd9600)),   32'd200520);
    check_eq("t35_19200",  32'(calc_t35(64'd50000000, 64'd19200)),  32'd100260);
    check_eq("t35_19201",  32'(calc_t35(64'd50000000, 64'd19201)),  32'd87500);

    // Frame A: four bytes, no CRC
    wr_byte(8'd0, 8'hC2); wr_byte(8'd1, 8'hB3); wr_byte(8'd2, 8'hA4); wr_byte(8'd3, 8'h95);
    clear_mon();
    send_frame(9'd4, 1'b0);
    @(negedge sys_clk);
    check_eq("A_busy_after_start", {31'h0, busy}, 32'd1);
    wait_frame_done(3000, seen);
    check_eq("A_done_seen", {31'h0, seen}, 32'd1);
    check_line("A", exp_a);
    for (int i = 1; i < 4; i++)
      check_eq($sformatf("A_done_to_start%0d", i),
               (i < gaps_q.size()) ? 32'(gaps_q[i]) : 32'hDEAD, 32'd3);
    check_eq("A_gap_cycles", 32'(gap_cycles), 32'(T35_FAST));
    check_eq("A_gap_first", 32'(gap_first - last_done_neg), 32'd1);
    check_eq("A_done_offset", 32'(fd_neg - last_done_neg), 32'(T35_FAST + 1));
    check_eq("A_err_cnt", 32'(err_cnt), 32'd0);
    check_eq("A_tx_data_stable", 32'(stab_viol), 32'd0);
    @(negedge sys_clk);
    check_eq("A_busy_low", {31'h0, busy}, 32'd0);
    check_eq("A_done_pulse_1cyc", {31'h0, frame_done}, 32'd0);

    // Frame B: Modbus read request with CRC
    wr_byte(8'd0, 8'h01); wr_byte(8'd1, 8'h03); wr_byte(8'd2, 8'h00);
    wr_byte(8'd3, 8'h00); wr_byte(8'd4, 8'h00); wr_byte(8'd5, 8'h01);
    clear_mon();
    send_frame(9'd6, 1'b1);
    wait_frame_done(3000, seen);
    check_eq("B_done_seen", {31'h0, seen}, 32'd1);
    check_line("B", exp_b);
    for (int i = 1; i < 6; i++)
      check_eq($sformatf("B_done_to_start%0d", i),
               (i < gaps_q.size()) ? 32'(gaps_q[i]) : 32'hDEAD, 32'd3);
    check_eq("B_crc_out", {16'h0, crc_out}, 32'h0A84);
    check_eq("B_gap_cycles", 32'(gap_cycles), 32'(T35_FAST));

    // Rejected lengths
    clear_mon();
    send_frame(9'd0, 1'b0);
    repeat (3) @(posedge sys_clk);
    send_frame(9'd257, 1'b0);
    repeat (5) @(posedge sys_clk); #1;
    check_eq("ERR_pulses", 32'(err_cnt), 32'd2);
    check_eq("ERR_no_tx", 32'(line_q.size()), 32'd0);
    check_eq("ERR_busy_cycles", 32'(busy_cycles), 32'd0);

    // Start and buffer write while busy are dropped
    clear_mon();
    send_frame(9'd4, 1'b0);
    wait_bytes(1, 200, seen);
    check_eq("MID_first_byte_seen", {31'h0, seen}, 32'd1);
    @(posedge sys_clk); #1;
    frame_start = 1'b1; frame_len = 9'd2;
    wr_en = 1'b1; wr_addr = 8'd0; wr_data = 8'hFF;
    @(posedge sys_clk); #1;
    frame_start = 1'b0; wr_en = 1'b0;
    wait_frame_done(3000, seen);
    check_eq("MID_done_seen", {31'h0, seen}, 32'd1);
    repeat (20) @(posedge sys_clk); #1;
    check_line("MID", exp_c);
    check_eq("MID_err_cnt", 32'(err_cnt), 32'd0);
    check_eq("MID_done_cnt", 32'(done_cnt), 32'd1);
    check_eq("MID_busy_idle", {31'h0, busy}, 32'd0);
    clear_mon();
    send_frame(9'd1, 1'b0);
    wait_frame_done(3000, seen);
    check_eq("MID2_done_seen", {31'h0, seen}, 32'd1);
    check_line("MID2", exp_d);

    // Reset during the second byte
    wr_byte(8'd0, 8'hC2); wr_byte(8'd1, 8'hB3); wr_byte(8'd2, 8'hA4); wr_byte(8'd3, 8'h95);
    clear_mon();
    send_frame(9'd4, 1'b0);
    wait_bytes(2, 200, seen);
    check_eq("RST_second_byte_seen", {31'h0, seen}, 32'd1);
    @(posedge sys_clk); #1;
    reset_n = 1'b0;
    #1;
    check_eq("RST_flags", {27'h0, busy, frame_done, frame_err, gap_active, tx_start}, 32'h0);
    check_eq("RST_tx_data", {24'h0, tx_data}, 32'h00);
    check_eq("RST_crc_out", {16'h0, crc_out}, 32'hFFFF);
    repeat (3) @(posedge sys_clk); #1;
    reset_n = 1'b1;
    repeat (40) @(posedge sys_clk); #1;
    check_eq("RST_no_more_tx", 32'(line_q.size()), 32'd2);
    check_eq("RST_busy", {31'h0, busy}, 32'd0);
    check_eq("RST_no_gap", 32'(gap_cycles), 32'd0);
    check_eq("RST_no_done", 32'(done_cnt), 32'd0);

    // 9600-baud instance: one byte, measure the gap
    @(posedge sys_clk); #1;
    wr_en_s = 1'b1; wr_addr_s = 8'd0; wr_data_s = 8'h5A;
    @(posedge sys_clk); #1;
    wr_en_s = 1'b0;
    frame_len_s = 9'd1; crc_en_s = 1'b0; frame_start_s = 1'b1;
    @(posedge sys_clk); #1;
    frame_start_s = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if (tx_start_s) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("SLOW_tx_start_seen", {31'h0, seen}, 32'd1);
    check_eq("SLOW_tx_data", {24'h0, tx_data_s}, 32'h5A);
    repeat (2) @(posedge sys_clk); #1;
    tx_done_s = 1'b1;
    @(posedge sys_clk); #1;
    tx_done_s = 1'b0;
    first_i = -1; done_i = -1; g = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge sys_clk);
      if (frame_done_s) begin
        done_i = i;
        break;
      end
      if (gap_active_s) begin
        if (first_i < 0) first_i = i;
        g++;
      end
    end
    check_eq("SLOW_gap_first", 32'(first_i), 32'd0);
    check_eq("SLOW_gap_cycles", 32'(g), 32'(T35_SLOW));
    check_eq("SLOW_done_index", 32'(done_i), 32'(T35_SLOW));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
